// File: rtl/usb_ep_stream_bridge.sv
// User-side bridge for one non-control USB endpoint: drains received packets into a
// valid/ready byte stream and packetizes an outgoing byte stream into fill transactions.
module usb_ep_stream_bridge #(
  parameter int MAX_PACKET_SIZE = 64,
  parameter int FLUSH_CYCLES    = 256,
  parameter bit SEND_ZLP        = 1'b1
) (
  input  logic       clk12_i,
  input  logic       rst_i,
  input  logic       EP_IN_dataAvailable_i,
  input  logic [7:0] EP_IN_data_i,
  output logic       EP_IN_popData_o,
  output logic       EP_IN_popTransDone_o,
  output logic       EP_IN_popTransSuccess_o,
  output logic       m_valid_o,
  output logic [7:0] m_data_o,
  input  logic       m_ready_i,
  output logic       rxPktEnd_o,
  input  logic       s_valid_i,
  input  logic [7:0] s_data_i,
  input  logic       s_last_i,
  output logic       s_ready_o,
  input  logic       EP_OUT_full_i,
  output logic       EP_OUT_dataValid_o,
  output logic [7:0] EP_OUT_data_o,
  output logic       EP_OUT_fillTransDone_o,
  output logic       EP_OUT_fillTransSuccess_o,
  output logic       txPktSent_o
);
  localparam int CW = $clog2(MAX_PACKET_SIZE + 1);
  localparam int FW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_PACKET_SIZE);
  localparam logic [FW-1:0] FLUSH_CNT = FW'(FLUSH_CYCLES);

  typedef enum logic {RX_STREAM, RX_COMMIT} rx_state_t;
  typedef enum logic [1:0] {TX_FILL, TX_COMMIT, TX_ZLP} tx_state_t;

  rx_state_t rx_state_q;
  tx_state_t tx_state_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          zlp_pending_q;
  logic          rx_pop, rx_commit;
  logic          tx_acc, tx_commit, zlp_set;

  // RX: pop straight through from the FWFT head; commit once the packet has drained.
  always_comb begin
    rx_pop    = (rx_state_q == RX_STREAM) && EP_IN_dataAvailable_i && m_ready_i;
    rx_cnt_d  = rx_cnt_q + CW'(rx_pop);
    rx_commit = (rx_state_q == RX_STREAM) && (rx_cnt_d != '0) &&
                (!EP_IN_dataAvailable_i || (rx_pop && (rx_cnt_d == MAX_CNT)));
  end

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      rx_state_q <= RX_STREAM;
      rx_cnt_q   <= '0;
    end else begin
      case (rx_state_q)
        RX_STREAM: begin
          rx_cnt_q <= rx_cnt_d;
          if (rx_commit) rx_state_q <= RX_COMMIT;
        end
        default: begin
          rx_cnt_q   <= '0;
          rx_state_q <= RX_STREAM;
        end
      endcase
    end
  end

  assign m_valid_o               = !rst_i && (rx_state_q == RX_STREAM) && EP_IN_dataAvailable_i;
  assign m_data_o                = m_valid_o ? EP_IN_data_i : 8'h00;
  assign EP_IN_popData_o         = m_valid_o && m_ready_i;
  assign EP_IN_popTransDone_o    = !rst_i && (rx_state_q == RX_COMMIT);
  assign EP_IN_popTransSuccess_o = EP_IN_popTransDone_o;
  assign rxPktEnd_o              = EP_IN_popTransDone_o;

  // TX: a partial packet is committed when the endpoint fills up, so neither side waits forever.
  always_comb begin
    tx_acc      = (tx_state_q == TX_FILL) && s_valid_i && !EP_OUT_full_i;
    tx_cnt_d    = tx_cnt_q + CW'(tx_acc);
    flush_cnt_d = flush_cnt_q;
    if (tx_acc)                flush_cnt_d = '0;
    else if (tx_cnt_q != '0)   flush_cnt_d = flush_cnt_q + 1'b1;
    zlp_set   = SEND_ZLP && tx_acc && s_last_i && (tx_cnt_d == MAX_CNT);
    tx_commit = (tx_state_q == TX_FILL) &&
                ((tx_acc && ((tx_cnt_d == MAX_CNT) || s_last_i)) ||
                 ((tx_cnt_q != '0) && EP_OUT_full_i) ||
                 ((FLUSH_CYCLES > 0) && (tx_cnt_q != '0) && !tx_acc &&
                  (flush_cnt_d == FLUSH_CNT)));
  end

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      tx_state_q    <= TX_FILL;
      tx_cnt_q      <= '0;
      flush_cnt_q   <= '0;
      zlp_pending_q <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_FILL: begin
          tx_cnt_q    <= tx_cnt_d;
          flush_cnt_q <= flush_cnt_d;
          if (tx_commit) begin
            tx_state_q    <= TX_COMMIT;
            zlp_pending_q <= zlp_set;
          end
        end
        TX_COMMIT: begin
          tx_cnt_q    <= '0;
          flush_cnt_q <= '0;
          tx_state_q  <= zlp_pending_q ? TX_ZLP : TX_FILL;
        end
        default: begin
          zlp_pending_q <= 1'b0;
          tx_state_q    <= TX_FILL;
        end
      endcase
    end
  end

  assign s_ready_o                 = !rst_i && (tx_state_q == TX_FILL) && !EP_OUT_full_i;
  assign EP_OUT_dataValid_o        = !rst_i && tx_acc;
  assign EP_OUT_data_o             = EP_OUT_dataValid_o ? s_data_i : 8'h00;
  assign EP_OUT_fillTransDone_o    = !rst_i && ((tx_state_q == TX_COMMIT) || (tx_state_q == TX_ZLP));
  assign EP_OUT_fillTransSuccess_o = EP_OUT_fillTransDone_o;
  assign txPktSent_o               = EP_OUT_fillTransDone_o;
endmodule

// File: tb/tb_usb_ep_stream_bridge.sv
// Directed bench for usb_ep_stream_bridge: instance a (MAX=8, FLUSH=16, ZLP=1) and
// instance b (MAX=8, FLUSH=0, ZLP=0) share one set of inputs.
module tb_usb_ep_stream_bridge;
  logic       clk = 1'b0;
  logic       rst;
  logic       ep_in_avail, m_ready, s_valid, s_last, ep_out_full;
  logic [7:0] ep_in_data, s_data;

  logic       a_pop, a_pdone, a_psucc, a_mvalid, a_rxend, a_sready, a_dv, a_fdone, a_fsucc, a_txsent;
  logic [7:0] a_mdata, a_odata;
  logic       b_pop, b_pdone, b_psucc, b_mvalid, b_rxend, b_sready, b_dv, b_fdone, b_fsucc, b_txsent;
  logic [7:0] b_mdata, b_odata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  int pos_q[$];
  int cyc_q[$];

  always #5 clk = ~clk;

  usb_ep_stream_bridge #(.MAX_PACKET_SIZE(8), .FLUSH_CYCLES(16), .SEND_ZLP(1'b1)) dut_a (
    .clk12_i(clk), .rst_i(rst),
    .EP_IN_dataAvailable_i(ep_in_avail), .EP_IN_data_i(ep_in_data),
    .EP_IN_popData_o(a_pop), .EP_IN_popTransDone_o(a_pdone), .EP_IN_popTransSuccess_o(a_psucc),
    .m_valid_o(a_mvalid), .m_data_o(a_mdata), .m_ready_i(m_ready), .rxPktEnd_o(a_rxend),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last), .s_ready_o(a_sready),
    .EP_OUT_full_i(ep_out_full), .EP_OUT_dataValid_o(a_dv), .EP_OUT_data_o(a_odata),
    .EP_OUT_fillTransDone_o(a_fdone), .EP_OUT_fillTransSuccess_o(a_fsucc), .txPktSent_o(a_txsent)
  );

  usb_ep_stream_bridge #(.MAX_PACKET_SIZE(8), .FLUSH_CYCLES(0), .SEND_ZLP(1'b0)) dut_b (
    .clk12_i(clk), .rst_i(rst),
    .EP_IN_dataAvailable_i(ep_in_avail), .EP_IN_data_i(ep_in_data),
    .EP_IN_popData_o(b_pop), .EP_IN_popTransDone_o(b_pdone), .EP_IN_popTransSuccess_o(b_psucc),
    .m_valid_o(b_mvalid), .m_data_o(b_mdata), .m_ready_i(m_ready), .rxPktEnd_o(b_rxend),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last), .s_ready_o(b_sready),
    .EP_OUT_full_i(ep_out_full), .EP_OUT_dataValid_o(b_dv), .EP_OUT_data_o(b_odata),
    .EP_OUT_fillTransDone_o(b_fdone), .EP_OUT_fillTransSuccess_o(b_fsucc), .txPktSent_o(b_txsent)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    ep_in_avail = 1'b0; ep_in_data = 8'h00; m_ready = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; ep_out_full = 1'b0;
  endtask

  task automatic reset_all();
    @(posedge clk); #1;
    rst = 1'b1; drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // FWFT source model: byte i is 0x11+i; the head advances only when the DUT pops.
  task automatic run_rx(input int nbytes, input int toggle_ready, input int ncyc);
    int idx = 0;
    exp_q.delete(); pos_q.delete(); cyc_q.delete();
    for (int i = 0; i < nbytes; i++) exp_q.push_back(8'(8'h11 + i));
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      ep_in_avail = (idx < nbytes);
      ep_in_data  = 8'(8'h11 + idx);
      m_ready     = (toggle_ready != 0) ? ((c % 2) == 0) : 1'b1;
      #1;
      if (!m_ready) check("rx_no_pop_when_not_ready", 32'(a_pop), 32'd0);
      if (a_pop) begin
        if (exp_q.size() == 0) check("rx_extra_pop", 32'd1, 32'd0);
        else check("rx_data", 32'(a_mdata), 32'(exp_q.pop_front()));
        idx++;
      end
      if (a_pdone) begin
        check("rx_commit_mvalid", 32'(a_mvalid), 32'd0);
        check("rx_commit_success", 32'(a_psucc), 32'd1);
        check("rx_commit_pktend", 32'(a_rxend), 32'd1);
        pos_q.push_back(idx);
        cyc_q.push_back(c);
      end
    end
    check("rx_all_popped", 32'(exp_q.size()), 32'd0);
    drive_idle();
  endtask

  // Stream source holds each byte (0xA0+i) until accepted; commits logged with byte count.
  task automatic run_tx(input int sel, input int nbytes, input bit last_end,
                        input int full_after, input int ncyc);
    int sent = 0;
    int since = 0;
    logic rdy, dv, done, succ, pkt;
    logic [7:0] dat;
    exp_q.delete(); pos_q.delete(); cyc_q.delete();
    for (int i = 0; i < nbytes; i++) exp_q.push_back(8'(8'hA0 + i));
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      s_valid     = (sent < nbytes);
      s_data      = 8'(8'hA0 + sent);
      s_last      = last_end && (sent == nbytes - 1);
      ep_out_full = (full_after >= 0) && (sent >= full_after);
      #1;
      rdy  = sel ? b_sready : a_sready;
      dv   = sel ? b_dv     : a_dv;
      dat  = sel ? b_odata  : a_odata;
      done = sel ? b_fdone  : a_fdone;
      succ = sel ? b_fsucc  : a_fsucc;
      pkt  = sel ? b_txsent : a_txsent;
      if (ep_out_full) begin
        check("tx_ready_while_full", 32'(rdy), 32'd0);
        check("tx_dv_while_full", 32'(dv), 32'd0);
      end
      check("tx_dv_handshake", 32'(dv), 32'(s_valid && rdy));
      if (dv) begin
        if (exp_q.size() == 0) check("tx_extra_byte", 32'd1, 32'd0);
        else check("tx_data", 32'(dat), 32'(exp_q.pop_front()));
        sent++;
        since++;
      end
      if (done) begin
        check("tx_commit_ready", 32'(rdy), 32'd0);
        check("tx_commit_success", 32'(succ), 32'd1);
        check("tx_commit_pktsent", 32'(pkt), 32'd1);
        pos_q.push_back(since);
        cyc_q.push_back(c);
        since = 0;
      end
    end
    drive_idle();
  endtask

  task automatic expect_commits(input string tag, input int n, input int l0, input int c0,
                                input int l1, input int c1);
    check({tag, "_count"}, 32'(pos_q.size()), 32'(n));
    if (n >= 1 && pos_q.size() >= 1) begin
      check({tag, "_len0"}, 32'(pos_q[0]), 32'(l0));
      check({tag, "_cyc0"}, 32'(cyc_q[0]), 32'(c0));
    end
    if (n >= 2 && pos_q.size() >= 2) begin
      check({tag, "_len1"}, 32'(pos_q[1]), 32'(l1));
      check({tag, "_cyc1"}, 32'(cyc_q[1]), 32'(c1));
    end
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1;
    drive_idle();
    ep_in_avail = 1'b1; m_ready = 1'b1; s_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_m_valid", 32'(a_mvalid), 32'd0);
    check("rst_pop", 32'(a_pop), 32'd0);
    check("rst_s_ready", 32'(a_sready), 32'd0);
    check("rst_dv", 32'(a_dv), 32'd0);
    check("rst_fdone", 32'(a_fdone), 32'd0);
    check("rst_pdone", 32'(a_pdone), 32'd0);
    check("rst_tx_cnt", 32'(dut_a.tx_cnt_q), 32'd0);
    drive_idle();
    reset_all();

    // RX
    run_rx(0, 0, 10);
    expect_commits("rx_idle", 0, 0, 0, 0, 0);
    run_rx(5, 0, 12);
    expect_commits("rx5", 1, 5, 6, 0, 0);
    run_rx(5, 1, 16);
    expect_commits("rx5_toggle", 1, 5, 10, 0, 0);
    run_rx(20, 0, 30);
    expect_commits("rx20", 3, 8, 8, 16, 17);
    if (pos_q.size() >= 3) begin
      check("rx20_len2", 32'(pos_q[2]), 32'd20);
      check("rx20_cyc2", 32'(cyc_q[2]), 32'd23);
    end

    // TX
    reset_all(); run_tx(0, 8, 1'b0, -1, 20);
    expect_commits("tx8_full_size", 1, 8, 8, 0, 0);
    reset_all(); run_tx(0, 8, 1'b1, -1, 20);
    expect_commits("tx8_last_zlp", 2, 8, 8, 0, 9);
    reset_all(); run_tx(1, 8, 1'b1, -1, 20);
    expect_commits("tx8_last_nozlp", 1, 8, 8, 0, 0);
    reset_all(); run_tx(0, 3, 1'b1, -1, 20);
    expect_commits("tx3_last", 1, 3, 3, 0, 0);
    reset_all(); run_tx(0, 3, 1'b0, -1, 40);
    expect_commits("tx3_flush", 1, 3, 19, 0, 0);
    reset_all(); run_tx(1, 3, 1'b0, -1, 40);
    expect_commits("tx3_noflush", 0, 0, 0, 0, 0);
    reset_all(); run_tx(0, 6, 1'b0, 4, 20);
    expect_commits("tx_full_partial", 1, 4, 5, 0, 0);

    // Reset in the middle of a fill
    reset_all();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = 8'(8'hA0 + c);
      #1 check("rst_mid_dv", 32'(a_dv), 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hA3;
    #1;
    check("rst_mid_ready", 32'(a_sready), 32'd0);
    check("rst_mid_dv_off", 32'(a_dv), 32'd0);
    check("rst_mid_fdone", 32'(a_fdone), 32'd0);
    @(posedge clk); #1;
    check("rst_mid_tx_cnt", 32'(dut_a.tx_cnt_q), 32'd0);
    check("rst_mid_flush_cnt", 32'(dut_a.flush_cnt_q), 32'd0);
    check("rst_mid_fdone2", 32'(a_fdone), 32'd0);
    check("rst_mid_odata", 32'(a_odata), 32'd0);
    rst = 1'b0; drive_idle();
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (a_fdone) done_cnt++;
    end
    check("rst_mid_no_commit", 32'(done_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
